// File: rtl/bram_port_ctrl.sv
// rtl/bram_port_ctrl.sv - dual-client BRAM port controller with collision arbitration and response FIFOs (optional: BRAM_CTRL_RR_EN)

module bram_rsp_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   count
);
  logic [W-1:0] q1, q2;
  logic [W-1:0] n0, n1, n2;
  logic [1:0]   base, ncount;
  logic         pop;

  assign pop = valid && ready;

  // shift the head out on pop, then append the new word at the first free slot
  always_comb begin
    n0   = data;
    n1   = q1;
    n2   = q2;
    base = count;
    if (pop) begin
      n0   = q1;
      n1   = q2;
      base = count - 2'd1;
    end
    if (push) begin
      case (base)
        2'd0:    n0 = push_data;
        2'd1:    n1 = push_data;
        default: n2 = push_data;
      endcase
    end
    ncount = base + {1'b0, push};
  end

  // head entry and valid are flops so the response outputs come straight from registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      q1    <= '0;
      q2    <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      data  <= n0;
      q1    <= n1;
      q2    <= n2;
      count <= ncount;
      valid <= (ncount != 2'd0);
    end
  end
endmodule

module bram_port_ctrl #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 1024,
  parameter int LOG       = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_a,
  output logic                 req_ready_a,
  input  logic                 req_we_a,
  input  logic [LOG-1:0]       req_addr_a,
  input  logic [RAM_WIDTH-1:0] req_wdata_a,
  input  logic                 req_valid_b,
  output logic                 req_ready_b,
  input  logic                 req_we_b,
  input  logic [LOG-1:0]       req_addr_b,
  input  logic [RAM_WIDTH-1:0] req_wdata_b,
  output logic                 rsp_valid_a,
  input  logic                 rsp_ready_a,
  output logic [RAM_WIDTH-1:0] rsp_data_a,
  output logic                 rsp_valid_b,
  input  logic                 rsp_ready_b,
  output logic [RAM_WIDTH-1:0] rsp_data_b,
  output logic                 wrena,
  output logic                 wrenb,
  output logic                 rdena,
  output logic                 rdenb,
  output logic [LOG-1:0]       addra,
  output logic [LOG-1:0]       addrb,
  output logic [RAM_WIDTH-1:0] dina,
  output logic [RAM_WIDTH-1:0] dinb,
  input  logic [RAM_WIDTH-1:0] douta,
  input  logic [RAM_WIDTH-1:0] doutb
);
  if (RAM_DEPTH > (1 << LOG)) begin : g_bad_depth
    $error("RAM_DEPTH does not fit in LOG address bits");
  end

  logic       pending_a, pending_b;
  logic [1:0] count_a, count_b;
  logic       credit_a, credit_b, elig_a, elig_b;
  logic       collision, win_a, fire_a, fire_b;

  // a read needs a guaranteed FIFO slot for itself and everything already in flight
  assign credit_a = ({1'b0, count_a} + {2'b00, pending_a}) < 3'd3;
  assign credit_b = ({1'b0, count_b} + {2'b00, pending_b}) < 3'd3;
  assign elig_a   = req_we_a || credit_a;
  assign elig_b   = req_we_b || credit_b;

  assign collision = req_valid_a && req_valid_b && (req_addr_a == req_addr_b) &&
                     (req_we_a || req_we_b);

`ifdef BRAM_CTRL_RR_EN
  logic turn_b;
  assign win_a = !turn_b;

  // winner alternates, advancing only when a collision actually lets one side through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            turn_b <= 1'b0;
    else if (collision && (fire_a || fire_b)) turn_b <= !turn_b;
  end
`else
  assign win_a = 1'b1;
`endif

  // the loser is held off only while the winner can really proceed, so a credit-starved
  // winner never deadlocks the other port
  assign req_ready_a = rst_n && elig_a && !(collision && !win_a && elig_b);
  assign req_ready_b = rst_n && elig_b && !(collision && win_a && elig_a);
  assign fire_a      = req_valid_a && req_ready_a;
  assign fire_b      = req_valid_b && req_ready_b;

  assign wrena = fire_a && req_we_a;
  assign rdena = fire_a && !req_we_a;
  assign wrenb = fire_b && req_we_b;
  assign rdenb = fire_b && !req_we_b;
  assign addra = req_addr_a;
  assign addrb = req_addr_b;
  assign dina  = req_wdata_a;
  assign dinb  = req_wdata_b;

  // pending marks the cycle where the RAM output register holds a read result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_a <= 1'b0;
      pending_b <= 1'b0;
    end else begin
      pending_a <= rdena;
      pending_b <= rdenb;
    end
  end

  bram_rsp_fifo #(.W(RAM_WIDTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .push(pending_a), .push_data(douta), .ready(rsp_ready_a),
    .valid(rsp_valid_a), .data(rsp_data_a), .count(count_a)
  );

  bram_rsp_fifo #(.W(RAM_WIDTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .push(pending_b), .push_data(doutb), .ready(rsp_ready_b),
    .valid(rsp_valid_b), .data(rsp_data_b), .count(count_b)
  );
endmodule

// File: tb/tb_bram_port_ctrl.sv
// tb/tb_bram_port_ctrl.sv - scoreboard bench for bram_port_ctrl against a reference memory model

module tb_bram_port_ctrl;
  localparam int W = 16;
  localparam int D = 1024;
  localparam int L = 10;
`ifdef BRAM_CTRL_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid_a = 0, req_we_a = 0, req_valid_b = 0, req_we_b = 0;
  logic [L-1:0] req_addr_a = '0, req_addr_b = '0;
  logic [W-1:0] req_wdata_a = '0, req_wdata_b = '0;
  logic rsp_ready_a = 1, rsp_ready_b = 1;
  logic req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b;
  logic [W-1:0] rsp_data_a, rsp_data_b;
  logic wrena, wrenb, rdena, rdenb;
  logic [L-1:0] addra, addrb;
  logic [W-1:0] dina, dinb;
  logic [W-1:0] douta = '0, doutb = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic [W-1:0] d; bit k; int c; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  logic [W-1:0] ref_mem [D];
  bit known [D];
  bit turn_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_port_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D), .LOG(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_we_a(req_we_a),
    .req_addr_a(req_addr_a), .req_wdata_a(req_wdata_a),
    .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_we_b(req_we_b),
    .req_addr_b(req_addr_b), .req_wdata_b(req_wdata_b),
    .rsp_valid_a(rsp_valid_a), .rsp_ready_a(rsp_ready_a), .rsp_data_a(rsp_data_a),
    .rsp_valid_b(rsp_valid_b), .rsp_ready_b(rsp_ready_b), .rsp_data_b(rsp_data_b),
    .wrena(wrena), .wrenb(wrenb), .rdena(rdena), .rdenb(rdenb),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta), .doutb(doutb)
  );

  // registered dual-port RAM, contents untouched by reset
  logic [W-1:0] bram [D];
  always @(posedge clk) begin
    if (wrena) bram[addra] <= dina;
    if (wrenb) bram[addrb] <= dinb;
    if (rdena) douta <= bram[addra];
    if (rdenb) doutb <= bram[addrb];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // request-side model: who should be granted, what the RAM should see, what each read returns
  logic coll, oka, okb, wina, ea, eb, fa, fb;
  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      turn_b = 0;
      chk("reset_ram_enables", {28'd0, wrena, wrenb, rdena, rdenb}, 32'd0);
      chk("reset_req_ready", {30'd0, req_ready_a, req_ready_b}, 32'd0);
    end else begin
      oka  = req_we_a || (qa.size() < 3);
      okb  = req_we_b || (qb.size() < 3);
      coll = req_valid_a && req_valid_b && (req_addr_a == req_addr_b) && (req_we_a || req_we_b);
      wina = !RR_EN || !turn_b;
      ea   = oka && !(coll && !wina && okb);
      eb   = okb && !(coll && wina && oka);
      chk("req_ready_a", {31'd0, req_ready_a}, {31'd0, ea});
      chk("req_ready_b", {31'd0, req_ready_b}, {31'd0, eb});
      fa = req_valid_a && ea;
      fb = req_valid_b && eb;
      chk("ram_en_a", {30'd0, wrena, rdena}, {30'd0, fa && req_we_a, fa && !req_we_a});
      chk("ram_en_b", {30'd0, wrenb, rdenb}, {30'd0, fb && req_we_b, fb && !req_we_b});
      if (fa) chk("ram_addr_a", {22'd0, addra}, {22'd0, req_addr_a});
      if (fb) chk("ram_addr_b", {22'd0, addrb}, {22'd0, req_addr_b});
      if (fa && req_we_a) chk("ram_din_a", {16'd0, dina}, {16'd0, req_wdata_a});
      if (fb && req_we_b) chk("ram_din_b", {16'd0, dinb}, {16'd0, req_wdata_b});
      if ((wrena || rdena) && (wrenb || rdenb) && (wrena || wrenb))
        chk("same_addr_write_at_ram", {31'd0, addra == addrb}, 32'd0);
      if (fa && req_we_a) begin ref_mem[req_addr_a] = req_wdata_a; known[req_addr_a] = 1; end
      if (fb && req_we_b) begin ref_mem[req_addr_b] = req_wdata_b; known[req_addr_b] = 1; end
      if (fa && !req_we_a) qa.push_back('{d: ref_mem[req_addr_a], k: known[req_addr_a], c: cyc});
      if (fb && !req_we_b) qb.push_back('{d: ref_mem[req_addr_b], k: known[req_addr_b], c: cyc});
      if (coll && (fa || fb)) turn_b = !turn_b;
    end
  end

  // response monitor: an entry becomes visible two cycles after its accept, in order
  logic eva, evb;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      chk("reset_rsp_a", {15'd0, rsp_valid_a, rsp_data_a}, 32'd0);
      chk("reset_rsp_b", {15'd0, rsp_valid_b, rsp_data_b}, 32'd0);
    end else begin
      eva = (qa.size() > 0) && (qa[0].c + 2 <= cyc);
      evb = (qb.size() > 0) && (qb[0].c + 2 <= cyc);
      chk("rsp_valid_a", {31'd0, rsp_valid_a}, {31'd0, eva});
      chk("rsp_valid_b", {31'd0, rsp_valid_b}, {31'd0, evb});
      if (eva) begin
        if (qa[0].k) chk("rsp_data_a", {16'd0, rsp_data_a}, {16'd0, qa[0].d});
        if (rsp_ready_a) void'(qa.pop_front());
      end
      if (evb) begin
        if (qb[0].k) chk("rsp_data_b", {16'd0, rsp_data_b}, {16'd0, qb[0].d});
        if (rsp_ready_b) void'(qb.pop_front());
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // hold each request until granted, then drop it
  task automatic xfer(input logic va, input logic wa, input logic [L-1:0] aa, input logic [W-1:0] da,
                      input logic vb, input logic wb, input logic [L-1:0] ab, input logic [W-1:0] db);
    logic ga, gb;
    req_valid_a = va; req_we_a = wa; req_addr_a = aa; req_wdata_a = da;
    req_valid_b = vb; req_we_b = wb; req_addr_b = ab; req_wdata_b = db;
    for (int t = 0; t < 40 && (req_valid_a || req_valid_b); t++) begin
      @(negedge clk);
      ga = req_valid_a && req_ready_a;
      gb = req_valid_b && req_ready_b;
      @(posedge clk);
      #1;
      if (ga) req_valid_a = 0;
      if (gb) req_valid_b = 0;
    end
    chk("xfer_granted", {30'd0, req_valid_a, req_valid_b}, 32'd0);
    req_valid_a = 0;
    req_valid_b = 0;
  endtask

  int acc;
  initial begin
    for (int i = 0; i < D; i++) begin ref_mem[i] = '0; known[i] = 0; end
    step(3);
    rst_n = 1;
    // write then read on A, first request right after reset release
    xfer(1, 1, 10'h010, 16'h1234, 0, 0, 0, 0);
    xfer(1, 0, 10'h010, 16'h0, 0, 0, 0, 0);
    step(4);
    for (int i = 0; i < 8; i++)
      xfer(1, 1, L'(i), W'(16'h0100 + i), 1, 1, L'(i + 8), W'(16'h0200 + i));
    // write/write collisions and a plain read/read share
    xfer(1, 1, 10'h020, 16'hAAAA, 1, 1, 10'h020, 16'h5555);
    xfer(1, 0, 10'h020, 16'h0, 0, 0, 0, 0);
    xfer(1, 1, 10'h020, 16'h1111, 1, 1, 10'h020, 16'h2222);
    xfer(1, 0, 10'h020, 16'h0, 1, 0, 10'h020, 16'h0);
    xfer(1, 1, 10'h030, 16'hBEEF, 0, 0, 0, 0);
    xfer(0, 0, 0, 0, 1, 0, 10'h030, 16'h0);
    step(4);
    // credit stall with response backpressure, then drain
    rsp_ready_a = 0;
    acc = 0;
    req_valid_a = 1; req_we_a = 0; req_addr_a = '0;
    for (int t = 0; t < 30 && acc < 5; t++) begin
      if (t == 8) begin
        chk("credit_stall_accepts", acc, 3);
        rsp_ready_a = 1;
      end
      @(negedge clk);
      if (req_ready_a) acc++;
      @(posedge clk);
      #1;
      req_addr_a = L'(acc);
      if (acc >= 5) req_valid_a = 0;
    end
    chk("credit_total_accepts", acc, 5);
    req_valid_a = 0;
    step(8);
    // reset pulse right after a read accept discards it
    xfer(1, 0, 10'h010, 16'h0, 0, 0, 0, 0);
    rst_n = 0;
    step(1);
    rst_n = 1;
    step(6);
    // random traffic on a small address window so collisions are frequent
    for (int n = 0; n < 800; n++) begin
      req_valid_a = $urandom_range(0, 1); req_we_a = $urandom_range(0, 1);
      req_addr_a = L'($urandom_range(0, 7)); req_wdata_a = W'($urandom);
      req_valid_b = $urandom_range(0, 1); req_we_b = $urandom_range(0, 1);
      req_addr_b = L'($urandom_range(0, 7)); req_wdata_b = W'($urandom);
      rsp_ready_a = ($urandom_range(0, 3) != 0);
      rsp_ready_b = ($urandom_range(0, 3) != 0);
      step(1);
    end
    req_valid_a = 0; req_valid_b = 0;
    rsp_ready_a = 1; rsp_ready_b = 1;
    step(10);
    chk("drained", qa.size() + qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
